// File: rtl/plab5_mcore_debug_dma.sv
// Burst READ/COPY debug access engine between the debug port and the memory-side debug channel.
// Optional address fence for low-domain commands: define PLAB5_DEBUG_DMA_SECURE_FENCE_EN.
module plab5_mcore_debug_dma #(
   parameter int unsigned p_addr_nbits = 32,
   parameter int unsigned p_data_nbits = 32,
   parameter int unsigned p_len_nbits = 8,
   parameter logic [p_addr_nbits-1:0] p_secure_base = 32'h8000_0000
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    dbg_req_val,
   output logic                    dbg_req_rdy,
   input  logic                    dbg_req_type,
   input  logic [p_addr_nbits-1:0] dbg_req_src_addr,
   input  logic [p_addr_nbits-1:0] dbg_req_dest_addr,
   input  logic [p_len_nbits-1:0]  dbg_req_len,
   input  logic                    dbg_req_domain,
   output logic                    mem_req_val,
   input  logic                    mem_req_rdy,
   output logic                    mem_req_type,
   output logic [p_addr_nbits-1:0] mem_req_addr,
   output logic [p_data_nbits-1:0] mem_req_data,
   output logic                    mem_req_domain,
   input  logic                    mem_resp_val,
   output logic                    mem_resp_rdy,
   input  logic [p_data_nbits-1:0] mem_resp_data,
   input  logic                    mem_resp_domain,
   output logic                    dbg_resp_val,
   input  logic                    dbg_resp_rdy,
   output logic [p_data_nbits-1:0] dbg_resp_data,
   output logic [1:0]              dbg_resp_status,
   output logic                    domain,
   output logic                    busy
);

   localparam int unsigned S = p_data_nbits / 8;
   localparam logic [p_addr_nbits-1:0] STRIDE = p_addr_nbits'(S);
   localparam logic [p_len_nbits-1:0] LEN_ONE = p_len_nbits'(1);

   localparam logic [1:0] ST_DATA   = 2'd0;
   localparam logic [1:0] ST_DONE   = 2'd1;
   localparam logic [1:0] ST_ERR    = 2'd2;
   localparam logic [1:0] ST_DENIED = 2'd3;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      RD_REQ    = 3'd1,
      RD_WAIT   = 3'd2,
      WR_REQ    = 3'd3,
      WR_WAIT   = 3'd4,
      DATA_RESP = 3'd5,
      STAT_RESP = 3'd6
   } state_t;

   state_t                  state_r, state_n;
   logic                    type_r, type_n;
   logic [p_addr_nbits-1:0] src_r, src_n;
   logic [p_addr_nbits-1:0] dest_r, dest_n;
   logic [p_len_nbits-1:0]  len_r, len_n;
   logic                    dom_r, dom_n;
   logic [p_len_nbits-1:0]  cnt_r, cnt_n;
   logic [p_data_nbits-1:0] word_r, word_n;
   logic [1:0]              stat_r, stat_n;

   logic [p_len_nbits-1:0]  cnt_inc;
   logic [p_addr_nbits-1:0] offset;
   logic                    fence_deny;

   assign cnt_inc = cnt_r + LEN_ONE;
   assign offset  = p_addr_nbits'(cnt_r) * STRIDE;

`ifdef PLAB5_DEBUG_DMA_SECURE_FENCE_EN
   localparam logic [p_addr_nbits:0] SPAN_ONE = (p_addr_nbits+1)'(1);
   localparam logic [p_addr_nbits:0] STRIDE_X = (p_addr_nbits+1)'(S);

   // Last word address computed one bit wider so a range running past the top is caught.
   function automatic logic range_hits_fence(input logic [p_addr_nbits-1:0] base,
                                             input logic [p_len_nbits-1:0]  len);
      logic [p_addr_nbits:0] last;
      last = {1'b0, base} + ((p_addr_nbits+1)'(len) - SPAN_ONE) * STRIDE_X;
      return last[p_addr_nbits] || (last[p_addr_nbits-1:0] >= p_secure_base);
   endfunction

   assign fence_deny = !dbg_req_domain &&
                       (range_hits_fence(dbg_req_src_addr, dbg_req_len) ||
                        (dbg_req_type && range_hits_fence(dbg_req_dest_addr, dbg_req_len)));
`else
   logic unused_fence_base;
   assign unused_fence_base = ^p_secure_base;
   assign fence_deny = 1'b0;
`endif

   always_comb begin
      state_n = state_r;
      type_n  = type_r;
      src_n   = src_r;
      dest_n  = dest_r;
      len_n   = len_r;
      dom_n   = dom_r;
      cnt_n   = cnt_r;
      word_n  = word_r;
      stat_n  = stat_r;
      case (state_r)
         IDLE: begin
            if (dbg_req_val) begin
               type_n = dbg_req_type;
               src_n  = dbg_req_src_addr;
               dest_n = dbg_req_dest_addr;
               len_n  = dbg_req_len;
               dom_n  = dbg_req_domain;
               cnt_n  = '0;
               if (dbg_req_len == '0) begin
                  state_n = STAT_RESP;
                  stat_n  = ST_DONE;
               end else if (fence_deny) begin
                  state_n = STAT_RESP;
                  stat_n  = ST_DENIED;
               end else begin
                  state_n = RD_REQ;
               end
            end
         end
         RD_REQ: begin
            if (mem_req_rdy) state_n = RD_WAIT;
         end
         RD_WAIT: begin
            if (mem_resp_val) begin
               if (mem_resp_domain != dom_r) begin
                  state_n = STAT_RESP;
                  stat_n  = ST_ERR;
               end else begin
                  word_n  = mem_resp_data;
                  state_n = type_r ? WR_REQ : DATA_RESP;
               end
            end
         end
         WR_REQ: begin
            if (mem_req_rdy) state_n = WR_WAIT;
         end
         WR_WAIT: begin
            if (mem_resp_val) begin
               if (mem_resp_domain != dom_r) begin
                  state_n = STAT_RESP;
                  stat_n  = ST_ERR;
               end else begin
                  cnt_n = cnt_inc;
                  if (cnt_inc == len_r) begin
                     state_n = STAT_RESP;
                     stat_n  = ST_DONE;
                  end else begin
                     state_n = RD_REQ;
                  end
               end
            end
         end
         DATA_RESP: begin
            if (dbg_resp_rdy) begin
               cnt_n = cnt_inc;
               if (cnt_inc == len_r) begin
                  state_n = STAT_RESP;
                  stat_n  = ST_DONE;
               end else begin
                  state_n = RD_REQ;
               end
            end
         end
         STAT_RESP: begin
            if (dbg_resp_rdy) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r <= IDLE;
         type_r  <= 1'b0;
         src_r   <= '0;
         dest_r  <= '0;
         len_r   <= '0;
         dom_r   <= 1'b0;
         cnt_r   <= '0;
         word_r  <= '0;
         stat_r  <= ST_DATA;
      end else begin
         state_r <= state_n;
         type_r  <= type_n;
         src_r   <= src_n;
         dest_r  <= dest_n;
         len_r   <= len_n;
         dom_r   <= dom_n;
         cnt_r   <= cnt_n;
         word_r  <= word_n;
         stat_r  <= stat_n;
      end
   end

   // Every output is a decode of registered state, so no rdy input reaches a val output.
   assign dbg_req_rdy     = (state_r == IDLE);
   assign mem_req_val     = (state_r == RD_REQ) || (state_r == WR_REQ);
   assign mem_req_type    = (state_r == WR_REQ);
   assign mem_req_addr    = ((state_r == WR_REQ) ? dest_r : src_r) + offset;
   assign mem_req_data    = word_r;
   assign mem_req_domain  = dom_r;
   assign mem_resp_rdy    = (state_r == IDLE) || (state_r == RD_WAIT) || (state_r == WR_WAIT);
   assign dbg_resp_val    = (state_r == DATA_RESP) || (state_r == STAT_RESP);
   assign dbg_resp_data   = (state_r == STAT_RESP) ? p_data_nbits'(cnt_r) : word_r;
   assign dbg_resp_status = (state_r == STAT_RESP) ? stat_r : ST_DATA;
   assign domain          = dom_r;
   assign busy            = (state_r != IDLE);

endmodule

// File: tb/tb_plab5_mcore_debug_dma.sv
// Randomized bench for plab5_mcore_debug_dma with a transaction-level reference model.
`timescale 1ns/1ps
module tb_plab5_mcore_debug_dma;

   localparam int S = 4;
   localparam logic [31:0] SECURE_BASE = 32'h8000_0000;
   localparam logic [1:0] ST_DATA = 2'd0, ST_DONE = 2'd1, ST_ERR = 2'd2, ST_DENIED = 2'd3;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        dbg_req_val, dbg_req_rdy, dbg_req_type, dbg_req_domain;
   logic [31:0] dbg_req_src_addr, dbg_req_dest_addr;
   logic [7:0]  dbg_req_len;
   logic        mem_req_val, mem_req_rdy, mem_req_type, mem_req_domain;
   logic [31:0] mem_req_addr, mem_req_data;
   logic        mem_resp_val, mem_resp_rdy, mem_resp_domain;
   logic [31:0] mem_resp_data;
   logic        dbg_resp_val, dbg_resp_rdy;
   logic [31:0] dbg_resp_data;
   logic [1:0]  dbg_resp_status;
   logic        domain, busy;

   plab5_mcore_debug_dma dut (
      .clk(clk), .reset(reset),
      .dbg_req_val(dbg_req_val), .dbg_req_rdy(dbg_req_rdy), .dbg_req_type(dbg_req_type),
      .dbg_req_src_addr(dbg_req_src_addr), .dbg_req_dest_addr(dbg_req_dest_addr),
      .dbg_req_len(dbg_req_len), .dbg_req_domain(dbg_req_domain),
      .mem_req_val(mem_req_val), .mem_req_rdy(mem_req_rdy), .mem_req_type(mem_req_type),
      .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data), .mem_req_domain(mem_req_domain),
      .mem_resp_val(mem_resp_val), .mem_resp_rdy(mem_resp_rdy), .mem_resp_data(mem_resp_data),
      .mem_resp_domain(mem_resp_domain),
      .dbg_resp_val(dbg_resp_val), .dbg_resp_rdy(dbg_resp_rdy), .dbg_resp_data(dbg_resp_data),
      .dbg_resp_status(dbg_resp_status), .domain(domain), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct { logic typ; logic [31:0] addr; logic [31:0] data; } mreq_t;
   typedef struct { logic [1:0] st; logic [31:0] data; } dresp_t;
   typedef struct { logic [31:0] data; logic dom; } mresp_t;

   mreq_t  exp_mem[$], act_mem[$];
   dresp_t exp_dbg[$], act_dbg[$];
   mresp_t resp_q[$];
   logic [31:0] mem [logic [31:0]];

   int n_checks = 0, n_pass = 0;
   bit mon_en = 0, auto_mem = 1, stall_en = 0, in_cmd = 0, expect_val_next = 0;
   logic cur_dom = 1'b0;
   int cur_err = -1, req_idx = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
   endtask

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
   endfunction

   function automatic bit fence_bad(input logic [31:0] base, input int len);
      longint unsigned last;
      last = longint'(base) + longint'(len - 1) * S;
      return (last > 64'hFFFF_FFFF) || (last >= longint'(SECURE_BASE));
   endfunction

   // Whole-command model: the list of memory requests and debug responses the command must produce.
   task automatic build_expect(input logic typ, input logic [31:0] src, input logic [31:0] dest,
                               input int len, input logic dom, input int err);
      logic [31:0] ov [logic [31:0]];
      logic [31:0] ra, wa, v;
      bit deny;
      exp_mem.delete();
      exp_dbg.delete();
      if (len == 0) begin
         exp_dbg.push_back('{ST_DONE, 32'd0});
         return;
      end
      deny = 0;
`ifdef PLAB5_DEBUG_DMA_SECURE_FENCE_EN
      deny = (dom == 1'b0) && (fence_bad(src, len) || (typ && fence_bad(dest, len)));
`endif
      if (deny) begin
         exp_dbg.push_back('{ST_DENIED, 32'd0});
         return;
      end
      for (int i = 0; i < len; i++) begin
         ra = src + i * S;
         v = ov.exists(ra) ? ov[ra] : mem_rd(ra);
         exp_mem.push_back('{1'b0, ra, 32'h0});
         if (!typ) begin
            if (err == i) begin exp_dbg.push_back('{ST_ERR, 32'(i)}); return; end
            exp_dbg.push_back('{ST_DATA, v});
         end else begin
            if (err == 2 * i) begin exp_dbg.push_back('{ST_ERR, 32'(i)}); return; end
            wa = dest + i * S;
            exp_mem.push_back('{1'b1, wa, v});
            ov[wa] = v;
            if (err == 2 * i + 1) begin exp_dbg.push_back('{ST_ERR, 32'(i)}); return; end
         end
      end
      exp_dbg.push_back('{ST_DONE, 32'(len)});
   endtask

   // Compare process: checks every handshake and the per-cycle control outputs.
   initial begin
      mreq_t  e;
      dresp_t d;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            if (expect_val_next) begin
               check("val_next_cycle", mem_req_val | dbg_resp_val, 1);
               expect_val_next = 0;
            end
            check("busy", busy, in_cmd);
            check("dbg_req_rdy", dbg_req_rdy, !in_cmd);
            if (in_cmd) check("domain_out", domain, cur_dom);
            if (dbg_req_val && dbg_req_rdy) begin
               in_cmd = 1;
               cur_dom = dbg_req_domain;
               req_idx = 0;
               expect_val_next = 1;
            end
            if (mem_req_val && mem_req_rdy) begin
               act_mem.push_back('{mem_req_type, mem_req_addr, mem_req_data});
               check("mem_req_expected", exp_mem.size() != 0, 1);
               if (exp_mem.size() != 0) begin
                  e = exp_mem.pop_front();
                  check("mem_req_type", mem_req_type, e.typ);
                  check("mem_req_addr", mem_req_addr, e.addr);
                  if (e.typ) check("mem_req_data", mem_req_data, e.data);
               end
               check("mem_req_domain", mem_req_domain, cur_dom);
               if (auto_mem) begin
                  if (mem_req_type) begin
                     mem[mem_req_addr] = mem_req_data;
                     resp_q.push_back('{$urandom, (req_idx == cur_err) ? ~cur_dom : cur_dom});
                  end else begin
                     resp_q.push_back('{mem_rd(mem_req_addr), (req_idx == cur_err) ? ~cur_dom : cur_dom});
                  end
               end
               req_idx++;
            end
            if (mem_resp_val && mem_resp_rdy && in_cmd) expect_val_next = 1;
            if (dbg_resp_val && dbg_resp_rdy) begin
               act_dbg.push_back('{dbg_resp_status, dbg_resp_data});
               check("dbg_resp_expected", exp_dbg.size() != 0, 1);
               if (exp_dbg.size() != 0) begin
                  d = exp_dbg.pop_front();
                  check("dbg_resp_status", dbg_resp_status, d.st);
                  check("dbg_resp_data", dbg_resp_data, d.data);
               end
               if (dbg_resp_status == ST_DATA) expect_val_next = 1;
               else in_cmd = 0;
            end
         end
      end
   end

   // Memory responder: in-order responses with random latency.
   initial begin
      mresp_t r;
      int     dly;
      bit     ok;
      mem_resp_val = 1'b0;
      mem_resp_data = '0;
      mem_resp_domain = 1'b0;
      forever begin
         @(posedge clk); #1;
         if (resp_q.size() > 0) begin
            r = resp_q.pop_front();
            dly = int'($urandom_range(0, 3));
            repeat (dly) begin @(posedge clk); #1; end
            mem_resp_val = 1'b1;
            mem_resp_data = r.data;
            mem_resp_domain = r.dom;
            ok = 0;
            for (int k = 0; k < 200 && !ok; k++) begin
               @(negedge clk);
               ok = mem_resp_rdy;
               @(posedge clk); #1;
            end
            mem_resp_val = 1'b0;
            check("mem_resp_accepted", ok, 1);
         end
      end
   end

   initial begin
      mem_req_rdy = 1'b1;
      dbg_resp_rdy = 1'b1;
      forever begin
         @(posedge clk); #1;
         mem_req_rdy  = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
         dbg_resp_rdy = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
   end

   task automatic run_cmd(input logic typ, input logic [31:0] src, input logic [31:0] dest,
                          input int len, input logic dom, input int err);
      bit ok;
      build_expect(typ, src, dest, len, dom, err);
      cur_err = err;
      @(posedge clk); #1;
      dbg_req_val = 1'b1;
      dbg_req_type = typ;
      dbg_req_src_addr = src;
      dbg_req_dest_addr = dest;
      dbg_req_len = 8'(len);
      dbg_req_domain = dom;
      ok = 0;
      for (int k = 0; k < 50 && !ok; k++) begin
         @(negedge clk);
         ok = dbg_req_rdy;
         @(posedge clk); #1;
      end
      dbg_req_val = 1'b0;
      check("cmd_accepted", ok, 1);
      ok = 0;
      for (int k = 0; k < 3000 && !ok; k++) begin
         @(negedge clk); #1;
         ok = !in_cmd && (exp_dbg.size() == 0);
      end
      check("cmd_complete", ok, 1);
      check("mem_reqs_all_seen", exp_mem.size(), 0);
   endtask

   initial begin
      #900_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt;
      logic typ, dom;
      int len, err;
      logic [31:0] src, dest;
      dbg_req_val = 1'b0;
      dbg_req_type = 1'b0;
      dbg_req_src_addr = '0;
      dbg_req_dest_addr = '0;
      dbg_req_len = '0;
      dbg_req_domain = 1'b0;

      #2;
      check("rst_mem_req_val", mem_req_val, 0);
      check("rst_dbg_resp_val", dbg_resp_val, 0);
      check("rst_busy", busy, 0);
      check("rst_domain", domain, 0);
      check("rst_mem_req_addr", mem_req_addr, 0);
      check("rst_mem_req_data", mem_req_data, 0);
      check("rst_dbg_resp_data", dbg_resp_data, 0);
      check("rst_dbg_resp_status", dbg_resp_status, 0);
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      check("rdy_after_reset", dbg_req_rdy, 1);
      mon_en = 1;

      // READ src=0x100 len=3
      mem[32'h100] = 32'hA; mem[32'h104] = 32'hB; mem[32'h108] = 32'hC;
      act_dbg.delete(); act_mem.delete();
      run_cmd(1'b0, 32'h100, 32'h0, 3, 1'b0, -1);
      check("rd_nresp", act_dbg.size(), 4);
      if (act_dbg.size() == 4) begin
         check("rd_d0", act_dbg[0].data, 32'hA);
         check("rd_d1", act_dbg[1].data, 32'hB);
         check("rd_d2", act_dbg[2].data, 32'hC);
         check("rd_done_st", act_dbg[3].st, ST_DONE);
         check("rd_done_cnt", act_dbg[3].data, 3);
      end
      check("rd_nmem", act_mem.size(), 3);
      if (act_mem.size() == 3) begin
         check("rd_a0", act_mem[0].addr, 32'h100);
         check("rd_a1", act_mem[1].addr, 32'h104);
         check("rd_a2", act_mem[2].addr, 32'h108);
      end

      // COPY 0x200 -> 0x300 len=2 with stalls
      stall_en = 1;
      mem[32'h200] = 32'h1111_1111; mem[32'h204] = 32'h2222_2222;
      act_dbg.delete(); act_mem.delete();
      run_cmd(1'b1, 32'h200, 32'h300, 2, 1'b0, -1);
      check("cp_nmem", act_mem.size(), 4);
      if (act_mem.size() == 4) begin
         check("cp_w0_type", act_mem[1].typ, 1);
         check("cp_w0_addr", act_mem[1].addr, 32'h300);
         check("cp_w0_data", act_mem[1].data, 32'h1111_1111);
         check("cp_w1_addr", act_mem[3].addr, 32'h304);
         check("cp_w1_data", act_mem[3].data, 32'h2222_2222);
      end
      check("cp_nresp", act_dbg.size(), 1);
      if (act_dbg.size() == 1) check("cp_done_cnt", act_dbg[0].data, 2);
      check("cp_mem300", mem_rd(32'h300), 32'h1111_1111);

      // len=0
      act_dbg.delete(); act_mem.delete();
      run_cmd(1'b0, 32'h40, 32'h0, 0, 1'b1, -1);
      check("len0_nmem", act_mem.size(), 0);
      check("len0_nresp", act_dbg.size(), 1);
      if (act_dbg.size() == 1) begin
         check("len0_st", act_dbg[0].st, ST_DONE);
         check("len0_cnt", act_dbg[0].data, 0);
      end

      // domain mismatch on second response
      mem[32'h400] = 32'h4444;
      act_dbg.delete(); act_mem.delete();
      run_cmd(1'b0, 32'h400, 32'h0, 3, 1'b1, 1);
      check("err_nresp", act_dbg.size(), 2);
      if (act_dbg.size() == 2) begin
         check("err_d0", act_dbg[0].data, 32'h4444);
         check("err_st", act_dbg[1].st, ST_ERR);
         check("err_cnt", act_dbg[1].data, 1);
      end
      @(negedge clk);
      check("err_idle", busy, 0);

      // fence boundary
      act_dbg.delete(); act_mem.delete();
      run_cmd(1'b0, 32'h7FFF_FFFC, 32'h0, 2, 1'b0, -1);
`ifdef PLAB5_DEBUG_DMA_SECURE_FENCE_EN
      check("fence_nmem", act_mem.size(), 0);
      if (act_dbg.size() == 1) check("fence_st", act_dbg[0].st, ST_DENIED);
`else
      check("nofence_nmem", act_mem.size(), 2);
      if (act_dbg.size() == 3) check("nofence_st", act_dbg[2].st, ST_DONE);
`endif
      act_dbg.delete(); act_mem.delete();
      run_cmd(1'b0, 32'h7FFF_FFFC, 32'h0, 2, 1'b1, -1);
      check("fence_h_nresp", act_dbg.size(), 3);
      if (act_dbg.size() == 3) check("fence_h_cnt", act_dbg[2].data, 2);

      // randomized commands
      for (int n = 0; n < 40; n++) begin
         typ = 1'($urandom_range(0, 1));
         dom = 1'($urandom_range(0, 1));
         len = int'($urandom_range(0, 6));
         src = $urandom & 32'h0000_0FFC;
         dest = $urandom & 32'h0000_0FFC;
         if ($urandom_range(0, 3) == 0) src = 32'hFFFF_FFF0 + ($urandom & 32'hC);
         if ($urandom_range(0, 4) == 0) dest = 32'h7FFF_FFF0 + ($urandom & 32'hC);
         err = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2 * len)) : -1;
         run_cmd(typ, src, dest, len, dom, err);
      end

      // reset during RD_WAIT of a COPY, then a stray response
      stall_en = 0;
      auto_mem = 0;
      mon_en = 0;
      repeat (2) @(posedge clk);
      #1;
      dbg_req_val = 1'b1; dbg_req_type = 1'b1; dbg_req_src_addr = 32'h500;
      dbg_req_dest_addr = 32'h600; dbg_req_len = 8'd2; dbg_req_domain = 1'b1;
      @(posedge clk); #1;
      dbg_req_val = 1'b0;
      cnt = 0;
      while (!(mem_req_val && mem_req_rdy) && cnt < 20) begin @(negedge clk); cnt++; end
      check("rst_test_read_issued", mem_req_val && !mem_req_type, 1);
      @(posedge clk); #1;
      check("rst_test_rd_wait", busy, 1);
      reset = 1'b0;
      #1;
      check("rst_async_busy", busy, 0);
      check("rst_async_domain", domain, 0);
      @(posedge clk); @(posedge clk); #1;
      reset = 1'b1;
      @(negedge clk);
      check("rst_rel_rdy", dbg_req_rdy, 1);
      check("rst_rel_resp_rdy", mem_resp_rdy, 1);
      resp_q.push_back('{32'hDEAD_BEEF, 1'b1});
      cnt = 0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (mem_req_val || dbg_resp_val || busy) cnt++;
      end
      check("stray_resp_ignored", cnt, 0);
      check("stray_no_write", mem.exists(32'h600), 0);

      in_cmd = 0;
      expect_val_next = 0;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
